// File: rtl/l2_cache.sv
// Direct-mapped, write-back, write-allocate L2 cache between an L1 and a
// line-granular memory. Whole lines move on every interface; offset bits of
// the L1 address are ignored and are zero on the memory address.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | ready for a request; latches address, data and operation
// S_LOOKUP   | compare latched tag against the indexed line, count hit/miss
// S_WRITEBACK| dirty victim line is being written to memory
// S_FILL     | requested line is being read from memory
// S_RESPOND  | one-cycle completion pulse on l2_hit
module l2_cache #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CACHE_SIZE = 4096,
  parameter int BLOCK_SIZE = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADDR_WIDTH-1:0]            l1_addr,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] l1_data_in,
  input  logic                             l1_read,
  input  logic                             l1_write,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] l1_data_out,
  output logic                             l2_ready,
  output logic                             l2_hit,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_out,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_in,
  output logic                             mem_read,
  output logic                             mem_write,
  input  logic                             mem_ready,
  output logic [15:0]                      hit_count,
  output logic [15:0]                      miss_count
);

  localparam int NUM_LINES = CACHE_SIZE / BLOCK_SIZE;
  localparam int OFFSET    = $clog2(BLOCK_SIZE);
  localparam int INDEX     = $clog2(NUM_LINES);
  localparam int TAG       = ADDR_WIDTH - INDEX - OFFSET;
  localparam int LINE_W    = BLOCK_SIZE * DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WRITEBACK,
    S_FILL,
    S_RESPOND
  } state_t;

  state_t state_q, state_d;

  logic [TAG-1:0]    req_tag;
  logic [INDEX-1:0]  req_index;
  logic              req_write;
  logic [LINE_W-1:0] req_data;

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG-1:0]       tag_mem  [NUM_LINES];
  logic [LINE_W-1:0]    data_mem [NUM_LINES];

  logic [TAG-1:0]    line_tag;
  logic [LINE_W-1:0] line_data;
  logic              line_hit;
  logic              victim_dirty;
  logic [ADDR_WIDTH-1:0] victim_addr;
  logic [ADDR_WIDTH-1:0] req_line_addr;

  logic              inst_we;
  logic [LINE_W-1:0] inst_data;
  logic              inst_dirty;

  // Offset bits select a word inside the line; whole lines are transferred.
  logic unused_offset;
  assign unused_offset = ^l1_addr[OFFSET-1:0];

  assign line_tag      = tag_mem[req_index];
  assign line_data     = data_mem[req_index];
  assign line_hit      = valid_q[req_index] && (line_tag == req_tag);
  assign victim_dirty  = valid_q[req_index] && dirty_q[req_index];
  assign victim_addr   = {line_tag, req_index, {OFFSET{1'b0}}};
  assign req_line_addr = {req_tag, req_index, {OFFSET{1'b0}}};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode and line-install control.
  always_comb begin
    state_d    = state_q;
    inst_we    = 1'b0;
    inst_data  = req_data;
    inst_dirty = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (l1_read || l1_write) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (line_hit) begin
          state_d = S_RESPOND;
          if (req_write) begin
            inst_we    = 1'b1;
            inst_dirty = 1'b1;
          end
        end else if (victim_dirty) begin
          state_d = S_WRITEBACK;
        end else if (!req_write) begin
          state_d = S_FILL;
        end else begin
          // Clean write miss: the whole line comes from L1, memory not needed.
          inst_we    = 1'b1;
          inst_dirty = 1'b1;
          state_d    = S_RESPOND;
        end
      end
      S_WRITEBACK: begin
        if (mem_ready) begin
          if (req_write) begin
            inst_we    = 1'b1;
            inst_dirty = 1'b1;
            state_d    = S_RESPOND;
          end else begin
            state_d = S_FILL;
          end
        end
      end
      S_FILL: begin
        if (mem_ready) begin
          inst_we   = 1'b1;
          inst_data = mem_data_in;
          state_d   = S_RESPOND;
        end
      end
      S_RESPOND: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Capture the request at the accepting edge so later L1 changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_tag   <= '0;
      req_index <= '0;
      req_write <= 1'b0;
      req_data  <= '0;
    end else if (state_q == S_IDLE && (l1_read || l1_write)) begin
      req_tag   <= l1_addr[ADDR_WIDTH-1 -: TAG];
      req_index <= l1_addr[OFFSET +: INDEX];
      req_write <= l1_write;
      req_data  <= l1_data_in;
    end
  end

  // Valid and dirty bits; cleared by reset so a reset drops all cached data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (inst_we) begin
      valid_q[req_index] <= 1'b1;
      dirty_q[req_index] <= inst_dirty;
    end
  end

  // Tag and data arrays; contents are qualified by valid_q, so no reset.
  always_ff @(posedge clk) begin
    if (inst_we) begin
      tag_mem[req_index]  <= req_tag;
      data_mem[req_index] <= inst_data;
    end
  end

  // Registered outputs, each derived from the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l2_ready     <= 1'b1;
      l2_hit       <= 1'b0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_addr     <= '0;
      mem_data_out <= '0;
      l1_data_out  <= '0;
      hit_count    <= '0;
      miss_count   <= '0;
    end else begin
      l2_ready  <= (state_d == S_IDLE);
      l2_hit    <= (state_d == S_RESPOND);
      mem_read  <= (state_d == S_FILL);
      mem_write <= (state_d == S_WRITEBACK);

      if (state_q == S_LOOKUP && state_d == S_WRITEBACK) begin
        mem_addr     <= victim_addr;
        mem_data_out <= line_data;
      end
      if (state_q != S_FILL && state_d == S_FILL) begin
        mem_addr <= req_line_addr;
      end

      if (state_q == S_LOOKUP && line_hit && !req_write) begin
        l1_data_out <= line_data;
      end
      if (state_q == S_FILL && mem_ready) begin
        l1_data_out <= mem_data_in;
      end

      if (state_q == S_LOOKUP) begin
        if (line_hit) begin
          if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
        end else begin
          if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_l2_cache.sv
// Testbench for l2_cache: transaction-level cache/memory model, directed
// scenarios with literal expectations, then randomized traffic.
module tb_l2_cache;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BS = 16;
  localparam int LW = DW * BS;
  localparam int NL = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] l1_addr;
  logic [LW-1:0] l1_data_in;
  logic          l1_read, l1_write;
  logic [LW-1:0] l1_data_out;
  logic          l2_ready, l2_hit;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_data_out, mem_data_in;
  logic          mem_read, mem_write, mem_ready;
  logic [15:0]   hit_count, miss_count;

  always #5 clk = ~clk;

  l2_cache dut (
    .clk(clk), .rst(rst),
    .l1_addr(l1_addr), .l1_data_in(l1_data_in),
    .l1_read(l1_read), .l1_write(l1_write),
    .l1_data_out(l1_data_out), .l2_ready(l2_ready), .l2_hit(l2_hit),
    .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_data_in(mem_data_in),
    .mem_read(mem_read), .mem_write(mem_write), .mem_ready(mem_ready),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: cache contents, backing memory, statistics, held output.
  logic          m_valid [NL];
  logic          m_dirty [NL];
  logic [19:0]   m_tag   [NL];
  logic [LW-1:0] m_data  [NL];
  logic [LW-1:0] mem_m [logic [31:0]];
  logic [15:0]   m_hits, m_misses;
  logic [LW-1:0] m_out;

  // Observations from the last transaction, used by directed checks.
  int            last_lat;
  bit            saw_wb, saw_rd;
  logic [31:0]   wb_addr_seen, rd_addr_seen;
  logic [LW-1:0] wb_data_seen;

  function automatic logic [LW-1:0] mem_get(input logic [31:0] line);
    logic [LW-1:0] b;
    if (mem_m.exists(line)) return mem_m[line];
    for (int w = 0; w < BS; w++) b[w*DW +: DW] = line ^ (32'h5A00_0000 + 32'(w) * 32'h0101_0001);
    return b;
  endfunction

  function automatic logic [LW-1:0] rand_block();
    logic [LW-1:0] b;
    for (int w = 0; w < BS; w++) b[w*DW +: DW] = $urandom;
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
      m_data[i]  = '0;
    end
    m_hits   = '0;
    m_misses = '0;
    m_out    = '0;
  endtask

  // Mutual exclusion of memory requests, every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) check("mem_rd_wr_exclusive", LW'(mem_read & mem_write), '0);
  end

  // One L1 request, driven at a negedge with the DUT idle; responds to memory
  // with the given mem_ready delays and checks every cycle until completion.
  task automatic do_req(input bit is_rd, input bit is_wr, input logic [31:0] addr,
                        input logic [LW-1:0] wdata, input int d_wb, input int d_rd);
    logic [7:0]    idx;
    logic [19:0]   tg;
    logic [31:0]   line, exp_wb_addr;
    logic [LW-1:0] exp_wb_data, exp_fill;
    bit            hit, wr, exp_wb, exp_rd, wb_done, rd_done, done, exp_mw, exp_mr;
    int            exp_lat, cnt, wb_wait, rd_wait;

    idx  = addr[11:4];
    tg   = addr[31:12];
    line = {tg, idx, 4'h0};
    wr   = is_wr;

    hit         = m_valid[idx] && (m_tag[idx] == tg);
    exp_wb      = !hit && m_valid[idx] && m_dirty[idx];
    exp_wb_addr = {m_tag[idx], idx, 4'h0};
    exp_wb_data = m_data[idx];
    exp_rd      = !hit && !wr;
    exp_fill    = mem_get(line);
    exp_lat     = 2 + (exp_wb ? d_wb + 1 : 0) + (exp_rd ? d_rd + 1 : 0);

    if (hit) begin
      if (m_hits != 16'hFFFF) m_hits++;
      if (wr) begin
        m_data[idx]  = wdata;
        m_dirty[idx] = 1'b1;
      end
    end else begin
      if (m_misses != 16'hFFFF) m_misses++;
      if (exp_wb) mem_m[exp_wb_addr] = exp_wb_data;
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_data[idx]  = wr ? wdata : exp_fill;
      m_dirty[idx] = wr;
    end

    saw_wb = 0; saw_rd = 0; wb_addr_seen = '0; rd_addr_seen = '0; wb_data_seen = '0;
    l1_addr = addr; l1_data_in = wdata; l1_read = is_rd; l1_write = is_wr;
    cnt = 0; done = 0; wb_done = 0; rd_done = 0; wb_wait = 0; rd_wait = 0;

    while (!done && cnt < 200) begin
      @(negedge clk);
      cnt++;
      mem_ready   = 1'b0;
      mem_data_in = rand_block();
      if (cnt == 1) begin
        l1_addr    = $urandom;
        l1_data_in = rand_block();
      end
      if (l2_hit) begin
        done = 1;
        check("latency", LW'(cnt), LW'(exp_lat));
        if (!wr) m_out = m_data[idx];
        check("l1_data_out_done", l1_data_out, m_out);
        check("hit_count", LW'(hit_count), LW'(m_hits));
        check("miss_count", LW'(miss_count), LW'(m_misses));
        l1_read  = 1'b0;
        l1_write = 1'b0;
      end else begin
        exp_mw = exp_wb && !wb_done && cnt >= 2;
        exp_mr = exp_rd && !rd_done && cnt >= 2 && (!exp_wb || wb_done);
        check("l2_ready_busy", LW'(l2_ready), '0);
        check("l1_data_out_hold", l1_data_out, m_out);
        check("mem_write", LW'(mem_write), LW'(exp_mw));
        check("mem_read", LW'(mem_read), LW'(exp_mr));
        if (mem_write && exp_mw) begin
          saw_wb = 1; wb_addr_seen = mem_addr; wb_data_seen = mem_data_out;
          check("wb_addr", LW'(mem_addr), LW'(exp_wb_addr));
          check("wb_data", mem_data_out, exp_wb_data);
          if (wb_wait == d_wb) begin
            mem_ready = 1'b1;
            wb_done   = 1;
          end else wb_wait++;
        end else if (mem_read && exp_mr) begin
          saw_rd = 1; rd_addr_seen = mem_addr;
          check("fill_addr", LW'(mem_addr), LW'(line));
          if (rd_wait == d_rd) begin
            mem_ready   = 1'b1;
            mem_data_in = exp_fill;
            rd_done     = 1;
          end else rd_wait++;
        end
      end
    end
    last_lat = cnt;
    check("l2_hit_seen", LW'(done), LW'(1'b1));
    l1_read = 1'b0; l1_write = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    check("l2_hit_single_pulse", LW'(l2_hit), '0);
    check("l2_ready_after", LW'(l2_ready), LW'(1'b1));
  endtask

  logic [LW-1:0] blk_b, blk_c;
  int            wait_cnt;

  initial begin
    rst = 1'b1;
    l1_addr = '0; l1_data_in = '0; l1_read = 0; l1_write = 0;
    mem_data_in = '0; mem_ready = 0;
    model_reset();
    repeat (3) @(negedge clk);

    check("rst_l2_ready", LW'(l2_ready), LW'(1'b1));
    check("rst_l2_hit", LW'(l2_hit), '0);
    check("rst_mem_rw", LW'({mem_read, mem_write}), '0);
    check("rst_mem_addr", LW'(mem_addr), '0);
    check("rst_mem_data_out", mem_data_out, '0);
    check("rst_l1_data_out", l1_data_out, '0);
    check("rst_counters", LW'({hit_count, miss_count}), '0);

    // Request presented on the release negedge: accepted at the first edge.
    rst = 1'b0;
    do_req(1, 0, 32'h0000_0100, '0, 0, 2);
    check("cold_fill_addr_lit", LW'(rd_addr_seen), LW'(32'h100));
    check("cold_latency_lit", LW'(last_lat), LW'(5));
    check("cold_miss_lit", LW'(miss_count), LW'(16'd1));
    check("cold_data_pattern", l1_data_out, mem_get(32'h100));

    do_req(1, 0, 32'h0000_0100, '0, 0, 0);
    check("rehit_latency_lit", LW'(last_lat), LW'(2));
    check("rehit_no_mem_lit", LW'({saw_rd, saw_wb}), '0);
    check("rehit_hit_lit", LW'(hit_count), LW'(16'd1));

    blk_b = rand_block();
    do_req(0, 1, 32'h0000_0200, blk_b, 0, 0);
    check("wmiss_latency_lit", LW'(last_lat), LW'(2));
    check("wmiss_no_mem_lit", LW'({saw_rd, saw_wb}), '0);
    do_req(1, 0, 32'h0000_0200, '0, 0, 0);
    check("read_b", l1_data_out, blk_b);
    check("read_b_hit_lit", LW'(hit_count), LW'(16'd2));

    do_req(1, 0, 32'h0001_0200, '0, 1, 0);
    check("evict_wb_addr_lit", LW'(wb_addr_seen), LW'(32'h200));
    check("evict_wb_data", wb_data_seen, blk_b);
    check("evict_fill_addr_lit", LW'(rd_addr_seen), LW'(32'h1_0200));
    check("evict_latency_lit", LW'(last_lat), LW'(5));

    blk_c = rand_block();
    do_req(1, 1, 32'h0000_0300, blk_c, 0, 0);
    do_req(1, 0, 32'h0000_0300, '0, 0, 0);
    check("both_strobes_read_c", l1_data_out, blk_c);

    for (int i = 0; i < 300; i++) begin
      int unsigned op;
      logic [31:0] a;
      op = $urandom_range(0, 2);
      a  = {20'($urandom_range(0, 3)), 8'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
      do_req(op != 1, op != 0, a, rand_block(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // Reset in the middle of a fill.
    l1_addr = 32'h0007_0400; l1_read = 1'b1;
    wait_cnt = 0;
    @(negedge clk);
    l1_read = 1'b0;
    while (!mem_read && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("fill_started", LW'(mem_read), LW'(1'b1));
    #2 rst = 1'b1;
    #1;
    check("rst_async_mem_read", LW'(mem_read), '0);
    check("rst_async_l2_ready", LW'(l2_ready), LW'(1'b1));
    check("rst_async_counters", LW'({hit_count, miss_count}), '0);
    check("rst_async_l1_data_out", l1_data_out, '0);
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("late_ready_ignored", LW'({l2_ready, mem_read, mem_write, l2_hit}), LW'(4'b1000));
    mem_ready = 1'b0;
    model_reset();
    do_req(1, 0, 32'h0007_0400, '0, 0, 0);
    check("post_rst_miss_lit", LW'(saw_rd), LW'(1'b1));
    check("post_rst_miss_cnt_lit", LW'(miss_count), LW'(16'd1));
    do_req(1, 0, 32'h0000_0100, '0, 0, 0);
    check("post_rst_invalid_lit", LW'(saw_rd), LW'(1'b1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
